// File: rtl/nibble_tx_pkg.sv
// Shared definitions for the nibble serial transmitter: FSM encoding and frame geometry.
package nibble_tx_pkg;

    localparam int FRAME_BITS = 7;
    localparam int DATA_BITS  = 4;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_e;

endpackage : nibble_tx_pkg

// File: rtl/nibble_tx_bittimer.sv
// Bit-period counter: counts BIT_CYCLES clocks per serial bit and flags the last one.
module nibble_tx_bittimer #(
    parameter int unsigned BIT_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic tick,
    output logic tick_next
);

    localparam logic [7:0] LAST = 8'(BIT_CYCLES - 1);

    logic [7:0] cnt_q;
    logic [7:0] cnt_d;

    always_comb begin
        if (clear) begin
            cnt_d = '0;
        end else if (cnt_q == LAST) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick      = (cnt_q == LAST);
    // Lets the parent register an output that lines up with the final cycle of a bit.
    assign tick_next = (cnt_d == LAST);

endmodule : nibble_tx_bittimer

// File: rtl/nibble_tx.sv
// Nibble serial transmitter: start, 4 data bits LSB-first, even parity, stop; registered outputs.
module nibble_tx
    import nibble_tx_pkg::*;
#(
    parameter int unsigned BIT_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] din,
    input  logic       load,
    output logic       sout,
    output logic       busy,
    output logic       done
);

    state_e     state_q, state_d;
    logic [3:0] shreg_q, shreg_d;
    logic [1:0] data_cnt_q, data_cnt_d;
    logic       parity_q, parity_d;
    logic       sout_q, sout_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic       tick;
    logic       tick_next;

    nibble_tx_bittimer #(
        .BIT_CYCLES(BIT_CYCLES)
    ) u_bittimer (
        .clk      (clk),
        .rst      (rst),
        .clear    (state_q == IDLE),
        .tick     (tick),
        .tick_next(tick_next)
    );

    always_comb begin
        // NOTE: every signal gets a default first so no path can infer a latch.
        state_d    = state_q;
        shreg_d    = shreg_q;
        data_cnt_d = data_cnt_q;
        parity_d   = parity_q;
        sout_d     = sout_q;

        unique case (state_q)
            IDLE: begin
                if (load) begin
                    state_d    = START;
                    shreg_d    = din;
                    parity_d   = ^din;
                    data_cnt_d = '0;
                    sout_d     = 1'b0;
                end
            end
            START: begin
                if (tick) begin
                    state_d = DATA;
                    sout_d  = shreg_q[0];
                end
            end
            DATA: begin
                if (tick) begin
                    if (data_cnt_q == 2'(DATA_BITS - 1)) begin
                        state_d = PARITY;
                        sout_d  = parity_q;
                    end else begin
                        data_cnt_d = data_cnt_q + 2'd1;
                        shreg_d    = shreg_q >> 1;
                        sout_d     = shreg_q[1];
                    end
                end
            end
            PARITY: begin
                if (tick) begin
                    state_d = STOP;
                    sout_d  = 1'b1;
                end
            end
            STOP: begin
                if (tick) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                sout_d  = 1'b1;
            end
        endcase

        busy_d = (state_d != IDLE);
        // Registered done must coincide with the final STOP cycle, so look one cycle ahead.
        done_d = (state_d == STOP) && tick_next;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            shreg_q    <= '0;
            data_cnt_q <= '0;
            parity_q   <= 1'b0;
            sout_q     <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            shreg_q    <= shreg_d;
            data_cnt_q <= data_cnt_d;
            parity_q   <= parity_d;
            sout_q     <= sout_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign sout = sout_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule : nibble_tx

// File: tb/tb_nibble_tx.sv
// Directed bench for nibble_tx: BIT_CYCLES=4 frame checks plus a BIT_CYCLES=1 streaming instance.
module tb_nibble_tx;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] din;
    logic       load;
    logic       sout, busy, done;

    logic       rst1;
    logic [3:0] din1;
    logic       load1;
    logic       sout1, busy1, done1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    nibble_tx #(.BIT_CYCLES(4)) dut (
        .clk (clk),
        .rst (rst),
        .din (din),
        .load(load),
        .sout(sout),
        .busy(busy),
        .done(done)
    );

    nibble_tx #(.BIT_CYCLES(1)) dut1 (
        .clk (clk),
        .rst (rst1),
        .din (din1),
        .load(load1),
        .sout(sout1),
        .busy(busy1),
        .done(done1)
    );

    // exp[i] is frame bit i (bit 0 = start). Samples taken at negedges after the accepting edge.
    // inject_k > 0 pulses load with din=1111 at that cycle to verify it is ignored.
    task automatic run_frame(input logic [3:0] d, input logic [6:0] exp,
                             input string name, input int inject_k);
        logic e_sout, e_busy, e_done;
        @(negedge clk);
        din  = d;
        load = 1'b1;
        for (int k = 1; k <= 36; k++) begin
            @(negedge clk);
            e_sout = (k <= 28) ? exp[(k - 1) / 4] : 1'b1;
            e_busy = (k <= 28);
            e_done = (k == 28);
            checks++;
            if (sout !== e_sout || busy !== e_busy || done !== e_done) begin
                errors++;
                $display("FAIL %s k=%0d: got sout=%b busy=%b done=%b, want sout=%b busy=%b done=%b",
                         name, k, sout, busy, done, e_sout, e_busy, e_done);
            end
            if (k == 1) begin
                load = 1'b0;
                din  = ~d;
            end
            if (inject_k > 0 && k == inject_k) begin
                din  = 4'b1111;
                load = 1'b1;
            end
            if (inject_k > 0 && k == inject_k + 1) load = 1'b0;
        end
    endtask

    task automatic test_reset();
        checks++;
        if (sout !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL reset4: got sout=%b busy=%b done=%b, want 1 0 0", sout, busy, done);
        end
        checks++;
        if (sout1 !== 1'b1 || busy1 !== 1'b0 || done1 !== 1'b0) begin
            errors++;
            $display("FAIL reset1: got sout=%b busy=%b done=%b, want 1 0 0", sout1, busy1, done1);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (sout !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL idle_after_reset: got sout=%b busy=%b done=%b, want 1 0 0", sout, busy, done);
        end
    endtask

    task automatic test_frames();
        run_frame(4'b1011, 7'b1110110, "frame_1011", 0);
        run_frame(4'b0000, 7'b1000000, "frame_0000", 0);
        run_frame(4'b0111, 7'b1101110, "frame_0111", 0);
    endtask

    task automatic test_ignored_load();
        run_frame(4'b0101, 7'b1001010, "frame_0101_ignore_load", 8);
    endtask

    task automatic test_abort();
        @(negedge clk);
        din  = 4'b0101;
        load = 1'b1;
        for (int k = 1; k <= 22; k++) begin
            @(negedge clk);
            if (k == 1) load = 1'b0;
        end
        // k=22 lies inside PARITY; assert reset between edges.
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (sout !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL async_abort: got sout=%b busy=%b done=%b, want 1 0 0", sout, busy, done);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            checks++;
            if (done !== 1'b0 || busy !== 1'b0 || sout !== 1'b1) begin
                errors++;
                $display("FAIL post_abort k=%0d: got sout=%b busy=%b done=%b, want 1 0 0",
                         k, sout, busy, done);
            end
        end
        run_frame(4'b0001, 7'b1100010, "frame_0001_after_abort", 0);
    endtask

    task automatic test_back_to_back();
        // din=1010 -> bits 0,0,1,0,1,0,1 then one idle cycle; period 8.
        logic [6:0] exp = 7'b1010100;
        logic e_sout, e_busy, e_done;
        int p;
        @(negedge clk);
        din1  = 4'b1010;
        load1 = 1'b1;
        rst1  = 1'b0;
        for (int k = 1; k <= 24; k++) begin
            @(negedge clk);
            p      = (k - 1) % 8;
            e_sout = (p < 7) ? exp[p] : 1'b1;
            e_busy = (p < 7);
            e_done = (p == 6);
            checks++;
            if (sout1 !== e_sout || busy1 !== e_busy || done1 !== e_done) begin
                errors++;
                $display("FAIL back_to_back k=%0d: got sout=%b busy=%b done=%b, want sout=%b busy=%b done=%b",
                         k, sout1, busy1, done1, e_sout, e_busy, e_done);
            end
        end
        load1 = 1'b0;
    endtask

    initial begin
        rst   = 1'b1;
        din   = 4'b0000;
        load  = 1'b0;
        rst1  = 1'b1;
        din1  = 4'b0000;
        load1 = 1'b0;
        #2;
        test_reset();
        test_frames();
        test_ignored_load();
        test_abort();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_nibble_tx
